// File: rtl/axis_pe_pkg.sv
// axis_pe_pkg: shared FSM state type and summary-word field layout for axis_pe_acc
package axis_pe_pkg;
  typedef enum logic [1:0] {IDLE, ACC, DROP, OUT} state_t;
  localparam int Y_LSB = 0;
  localparam int Y_W = 8;
  localparam int CNT_LSB = 24;
  localparam int CNT_W = 8;
  localparam int SUM_W = 24;
endpackage

// File: rtl/axis_pe_acc_if.sv
// axis_pe_acc_if: AXI-Stream channel bundle with master/slave views
interface axis_pe_acc_if;
  logic [31:0] tdata;
  logic tvalid;
  logic tready;
  logic tlast;
  modport master(output tdata, output tvalid, output tlast, input tready);
  modport slave(input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_pe_acc_sat_add.sv
// sat_add: unsigned W-bit plus 8-bit adder, saturating at all-ones when SAT else wrapping
module sat_add #(
  parameter int W = 24,
  parameter bit SAT = 1'b0
) (
  input  logic [W-1:0] a,
  input  logic [7:0]   b,
  output logic [W-1:0] y
);
  logic [W:0] s;
  assign s = {1'b0, a} + (W+1)'(b);
  assign y = (SAT && s[W]) ? '1 : s[W-1:0];
endmodule

// File: rtl/axis_pe_acc.sv
// axis_pe_acc: per-packet byte accumulator emitting {count, sum}; AXIS_PE_ACC_SAT_EN makes the sum saturate instead of wrap
module axis_pe_acc
  import axis_pe_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input logic aclk,
  input logic areset,
  input logic en,
  axis_pe_acc_if.slave s_axis,
  axis_pe_acc_if.master m_axis
);
`ifdef AXIS_PE_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  state_t st, st_n;
  logic [ACC_W-1:0] sum, sum_n, add;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [31:0] dout;
  logic vld;
  logic acc;
  logic [Y_W-1:0] y;
  logic unused_hi;
  assign y = s_axis.tdata[Y_LSB +: Y_W];
  assign unused_hi = ^s_axis.tdata[31:Y_W];
  assign s_axis.tready = !areset && (st != OUT || m_axis.tready);
  assign acc = s_axis.tvalid && s_axis.tready;
  assign m_axis.tvalid = vld;
  assign m_axis.tlast = vld;
  assign m_axis.tdata = dout;
  sat_add #(.W(ACC_W), .SAT(SAT)) u_add (.a(sum), .b(y), .y(add));
  // next state and next accumulator/count for the accepted beat, if any
  always_comb begin
    st_n = st;
    sum_n = sum;
    cnt_n = cnt;
    case (st)
      IDLE, OUT: begin
        if (st == OUT && m_axis.tready) st_n = IDLE;
        if (acc) begin
          st_n = en ? (s_axis.tlast ? OUT : ACC) : (s_axis.tlast ? IDLE : DROP);
          sum_n = en ? ACC_W'(y) : sum;
          cnt_n = en ? CNT_W'(1) : cnt;
        end
      end
      ACC: if (acc) begin
        sum_n = add;
        cnt_n = cnt + CNT_W'(cnt != '1);
        st_n = s_axis.tlast ? OUT : ACC;
      end
      DROP: if (acc && s_axis.tlast) st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end
  // state, accumulators and the summary word, captured as the closing beat is accepted
  always_ff @(posedge aclk) begin
    if (areset) begin
      st <= IDLE;
      sum <= '0;
      cnt <= '0;
      dout <= '0;
      vld <= 1'b0;
    end else begin
      st <= st_n;
      sum <= sum_n;
      cnt <= cnt_n;
      vld <= st_n == OUT;
      if (acc && st_n == OUT) begin
        dout[CNT_LSB +: CNT_W] <= cnt_n;
        dout[0 +: SUM_W] <= SUM_W'(sum_n);
      end
    end
  end
endmodule

// File: tb/tb_axis_pe_acc.sv
// tb_axis_pe_acc: randomized bench for axis_pe_acc at ACC_W=24 and ACC_W=10 against a packet-level model
module tb_axis_pe_acc;
  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic en = 1'b0;
  logic s_tvalid = 1'b0;
  logic s_tlast = 1'b0;
  logic [31:0] s_tdata = '0;
  logic m_tready = 1'b1;
  int errors = 0;
  int checks = 0;
  bit rnd_rdy = 1'b0;
  bit in_pkt = 1'b0;
  bit keep = 1'b0;
  int n = 0;
  longint total = 0;
  logic [32:0] got[2][$];
  logic [32:0] exp_q[2][$];

  axis_pe_acc_if s0();
  axis_pe_acc_if m0();
  axis_pe_acc_if s1();
  axis_pe_acc_if m1();
  assign s0.tvalid = s_tvalid;
  assign s0.tdata = s_tdata;
  assign s0.tlast = s_tlast;
  assign m0.tready = m_tready;
  assign s1.tvalid = s_tvalid;
  assign s1.tdata = s_tdata;
  assign s1.tlast = s_tlast;
  assign m1.tready = m_tready;

  axis_pe_acc dut0 (.aclk(aclk), .areset(areset), .en(en), .s_axis(s0), .m_axis(m0));
  axis_pe_acc #(.ACC_W(10)) dut1 (.aclk(aclk), .areset(areset), .en(en), .s_axis(s1), .m_axis(m1));

  always #5 aclk = ~aclk;

  always @(negedge aclk) begin
    if (!areset && m0.tvalid && m_tready) got[0].push_back({m0.tlast, m0.tdata});
    if (!areset && m1.tvalid && m_tready) got[1].push_back({m1.tlast, m1.tdata});
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  function automatic logic [32:0] model_word(int w, int cnt, longint tot);
    longint lim, s;
    lim = (longint'(1) << w) - 1;
`ifdef AXIS_PE_ACC_SAT_EN
    s = tot > lim ? lim : tot;
`else
    s = tot & lim;
`endif
    return {1'b1, 8'(cnt > 255 ? 255 : cnt), 24'(s)};
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(input int k);
    s_tvalid = 1'b0;
    repeat (k) begin
      if (rnd_rdy) m_tready = $urandom_range(0, 3) != 0;
      tick();
    end
  endtask

  task automatic drain();
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic send_beat(input logic [7:0] y, input bit last, input bit e, output int waited);
    s_tvalid = 1'b1;
    s_tdata = {24'($urandom), y};
    s_tlast = last;
    en = e;
    if (rnd_rdy) m_tready = $urandom_range(0, 3) != 0;
    waited = 0;
    @(negedge aclk);
    while (!s0.tready && waited < 100) begin
      tick();
      if (rnd_rdy) m_tready = $urandom_range(0, 3) != 0;
      waited++;
      @(negedge aclk);
    end
    if (!s0.tready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got tready=0 want 1");
    end else begin
      if (!in_pkt) begin
        in_pkt = 1'b1;
        keep = e;
        n = 0;
        total = 0;
      end
      n++;
      total += y;
      if (last) begin
        in_pkt = 1'b0;
        if (keep) begin
          exp_q[0].push_back(model_word(24, n, total));
          exp_q[1].push_back(model_word(10, n, total));
        end
      end
    end
    tick();
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    @(negedge aclk);
    checks++;
    if (s0.tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b want 0", s0.tready); end
    checks++;
    if (m0.tvalid !== 1'b0 || m0.tlast !== 1'b0) begin errors++; $display("FAIL reset_valid got %b/%b want 0/0", m0.tvalid, m0.tlast); end
    checks++;
    if (m0.tdata !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 00000000", m0.tdata); end
    tick();
    areset = 1'b0;
    @(negedge aclk);
    checks++;
    if (s0.tready !== 1'b1 || s1.tready !== 1'b1) begin errors++; $display("FAIL post_reset_tready got %b/%b want 1/1", s0.tready, s1.tready); end
    tick();
  endtask

  task automatic test_basic();
    int w;
    m_tready = 1'b1;
    send_beat(8'd3, 1'b0, 1'b1, w);
    send_beat(8'd5, 1'b0, 1'b1, w);
    send_beat(8'd7, 1'b1, 1'b1, w);
    @(negedge aclk);
    checks++;
    if (m0.tvalid !== 1'b1 || m0.tlast !== 1'b1 || m0.tdata !== 32'h0300000F) begin
      errors++;
      $display("FAIL basic_out got v=%b l=%b d=%h want v=1 l=1 d=0300000f", m0.tvalid, m0.tlast, m0.tdata);
    end
    tick();
    @(negedge aclk);
    checks++;
    if (m0.tvalid !== 1'b0) begin errors++; $display("FAIL basic_single got tvalid=%b want 0", m0.tvalid); end
    tick();
    for (int d = 0; d < 2; d++) begin
      got[d].delete();
      exp_q[d].delete();
    end
  endtask

  task automatic test_drop();
    int w;
    send_beat(8'h11, 1'b0, 1'b0, w);
    send_beat(8'h12, 1'b0, 1'b1, w);
    send_beat(8'h13, 1'b0, 1'b0, w);
    send_beat(8'h14, 1'b1, 1'b1, w);
    send_beat(8'h2A, 1'b1, 1'b1, w);
    send_beat(8'd1, 1'b0, 1'b1, w);
    send_beat(8'd2, 1'b0, 1'b0, w);
    send_beat(8'd3, 1'b1, 1'b0, w);
    drain();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (got[d].size() != exp_q[d].size()) begin
        errors++;
        $display("FAIL drop_count dut%0d got %0d want %0d", d, got[d].size(), exp_q[d].size());
      end else for (int i = 0; i < got[d].size(); i++) begin
        checks++;
        if (got[d][i] !== exp_q[d][i]) begin errors++; $display("FAIL drop_word dut%0d[%0d] got %h want %h", d, i, got[d][i], exp_q[d][i]); end
      end
      got[d].delete();
      exp_q[d].delete();
    end
  endtask

  task automatic test_backpressure();
    int w;
    logic [31:0] held;
    m_tready = 1'b0;
    send_beat(8'h11, 1'b0, 1'b1, w);
    send_beat(8'h22, 1'b1, 1'b1, w);
    @(negedge aclk);
    held = m0.tdata;
    checks++;
    if (m0.tvalid !== 1'b1 || held !== 32'h02000033) begin errors++; $display("FAIL bp_out got v=%b d=%h want v=1 d=02000033", m0.tvalid, held); end
    s_tvalid = 1'b1;
    s_tdata = 32'h00000055;
    s_tlast = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (s0.tready !== 1'b0 || m0.tvalid !== 1'b1 || m0.tdata !== held) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got rdy=%b v=%b d=%h want rdy=0 v=1 d=%h", k, s0.tready, m0.tvalid, m0.tdata, held);
      end
      tick();
      if (k < 4) @(negedge aclk);
    end
    m_tready = 1'b1;
    send_beat(8'h44, 1'b1, 1'b1, w);
    checks++;
    if (w != 0) begin errors++; $display("FAIL bp_same_cycle_accept got wait=%0d want 0", w); end
    drain();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (got[d].size() != exp_q[d].size()) begin
        errors++;
        $display("FAIL bp_count dut%0d got %0d want %0d", d, got[d].size(), exp_q[d].size());
      end else for (int i = 0; i < got[d].size(); i++) begin
        checks++;
        if (got[d][i] !== exp_q[d][i]) begin errors++; $display("FAIL bp_word dut%0d[%0d] got %h want %h", d, i, got[d][i], exp_q[d][i]); end
      end
      got[d].delete();
      exp_q[d].delete();
    end
  endtask

  task automatic test_overflow();
    int w;
    for (int j = 0; j < 5; j++) send_beat(8'hFF, j == 4, 1'b1, w);
    drain();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (got[d].size() != exp_q[d].size()) begin
        errors++;
        $display("FAIL ovf_count dut%0d got %0d want %0d", d, got[d].size(), exp_q[d].size());
      end else for (int i = 0; i < got[d].size(); i++) begin
        checks++;
        if (got[d][i] !== exp_q[d][i]) begin errors++; $display("FAIL ovf_word dut%0d[%0d] got %h want %h", d, i, got[d][i], exp_q[d][i]); end
      end
      got[d].delete();
      exp_q[d].delete();
    end
  endtask

  task automatic test_count_sat();
    int w;
    for (int j = 0; j < 300; j++) send_beat(8'd1, j == 299, 1'b1, w);
    drain();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (got[d].size() != exp_q[d].size()) begin
        errors++;
        $display("FAIL cnt_count dut%0d got %0d want %0d", d, got[d].size(), exp_q[d].size());
      end else for (int i = 0; i < got[d].size(); i++) begin
        checks++;
        if (got[d][i] !== exp_q[d][i]) begin errors++; $display("FAIL cnt_word dut%0d[%0d] got %h want %h", d, i, got[d][i], exp_q[d][i]); end
      end
      got[d].delete();
      exp_q[d].delete();
    end
  endtask

  task automatic test_back_to_back();
    int w, waits;
    waits = 0;
    m_tready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      send_beat(8'($urandom), 1'b1, 1'b1, w);
      waits += w;
    end
    for (int j = 0; j < 6; j++) begin
      send_beat(8'($urandom), j % 3 == 2, 1'b1, w);
      waits += w;
    end
    checks++;
    if (waits != 0) begin errors++; $display("FAIL b2b_bubbles got %0d want 0", waits); end
    drain();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (got[d].size() != exp_q[d].size()) begin
        errors++;
        $display("FAIL b2b_count dut%0d got %0d want %0d", d, got[d].size(), exp_q[d].size());
      end else for (int i = 0; i < got[d].size(); i++) begin
        checks++;
        if (got[d][i] !== exp_q[d][i]) begin errors++; $display("FAIL b2b_word dut%0d[%0d] got %h want %h", d, i, got[d][i], exp_q[d][i]); end
      end
      got[d].delete();
      exp_q[d].delete();
    end
  endtask

  task automatic test_reset_mid();
    int w;
    send_beat(8'h40, 1'b0, 1'b1, w);
    send_beat(8'h41, 1'b0, 1'b1, w);
    areset = 1'b1;
    tick();
    @(negedge aclk);
    checks++;
    if (s0.tready !== 1'b0 || m0.tvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_state got rdy=%b v=%b want 0/0", s0.tready, m0.tvalid); end
    tick();
    areset = 1'b0;
    in_pkt = 1'b0;
    m_tready = 1'b0;
    send_beat(8'h77, 1'b1, 1'b1, w);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    for (int d = 0; d < 2; d++) void'(exp_q[d].pop_back());
    send_beat(8'd9, 1'b1, 1'b1, w);
    drain();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (got[d].size() != exp_q[d].size()) begin
        errors++;
        $display("FAIL rst_mid_count dut%0d got %0d want %0d", d, got[d].size(), exp_q[d].size());
      end else for (int i = 0; i < got[d].size(); i++) begin
        checks++;
        if (got[d][i] !== exp_q[d][i]) begin errors++; $display("FAIL rst_mid_word dut%0d[%0d] got %h want %h", d, i, got[d][i], exp_q[d][i]); end
      end
      got[d].delete();
      exp_q[d].delete();
    end
  endtask

  task automatic test_random();
    int w, len;
    bit first;
    rnd_rdy = 1'b1;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 8);
      first = $urandom_range(0, 4) != 0;
      for (int j = 0; j < len; j++) begin
        send_beat(8'($urandom), j == len - 1, j == 0 ? first : 1'($urandom_range(0, 1)), w);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    end
    rnd_rdy = 1'b0;
    drain();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (got[d].size() != exp_q[d].size()) begin
        errors++;
        $display("FAIL rand_count dut%0d got %0d want %0d", d, got[d].size(), exp_q[d].size());
      end else for (int i = 0; i < got[d].size(); i++) begin
        checks++;
        if (got[d][i] !== exp_q[d][i]) begin errors++; $display("FAIL rand_word dut%0d[%0d] got %h want %h", d, i, got[d][i], exp_q[d][i]); end
      end
      got[d].delete();
      exp_q[d].delete();
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_drop();
    test_backpressure();
    test_overflow();
    test_count_sat();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
